fetch_unit: RTL and testbench

//   Instruction-fetch requester paired with the instruction memory (sync read, 1-cycle latency).

---
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch requester for a synchronous-read instruction
// memory with one cycle of read latency.
//
// The unit drives a PC stream as word addresses, tags each returned word
// with its PC, and delivers (pc, inst) pairs to decode over valid/ready.
// A two-entry skid buffer absorbs decode stalls. A redirect flushes all
// in-flight and buffered fetches and restarts fetching at the target PC.
//
// Ports:
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   imem_addr       word index presented to instruction memory
//   imem_rdata      memory read data for the previous cycle's address
//   redirect_valid  load redirect_pc and flush everything in flight
//   redirect_pc     target byte PC (bits [1:0] ignored)
//   out_valid       buffer head holds a fetched instruction
//   out_ready       decode accepts the head this cycle
//   out_pc          byte PC of the head instruction
//   out_inst        head instruction word
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    localparam int         WORD_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [WORD_LEN-1:0] imem_addr,
    input  logic [WORD_LEN-1:0] imem_rdata,
    input  logic                redirect_valid,
    input  logic [WORD_LEN-1:0] redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_LEN-1:0] out_pc,
    output logic [WORD_LEN-1:0] out_inst
);

    localparam logic [WORD_LEN-1:0] NOP      = 32'h0000_0013;
    localparam logic [WORD_LEN-1:0] PC_ALIGN = 32'hFFFF_FFFC;

    // Request / response tracking
    logic [WORD_LEN-1:0] req_pc_reg,    req_pc_next;
    logic                rsp_valid_reg, rsp_valid_next;
    logic [WORD_LEN-1:0] rsp_pc_reg,    rsp_pc_next;

    // Skid buffer bookkeeping
    logic [1:0]          occ_reg,  occ_next;
    logic                head_reg, head_next;

    // Skid buffer storage
    logic [WORD_LEN-1:0] buf_pc_reg   [2];
    logic [WORD_LEN-1:0] buf_inst_reg [2];

    logic       pop;
    logic       push;
    logic       issue;
    logic       tail;
    logic [2:0] fill;

    // Next-state logic
    always_comb begin
        pop   = (occ_reg != 2'd0) && out_ready;
        push  = rsp_valid_reg;
        // Buffer occupancy once the word already in flight has landed.
        // pop implies occ_reg >= 1, so this never underflows.
        fill  = {1'b0, occ_reg} + {2'b00, rsp_valid_reg} - {2'b00, pop};
        // A new request is only made if its data is guaranteed a slot.
        issue = (fill < 3'd2);
        // With occ=2 no push can arrive, so only occ 0/1 matter here.
        tail  = head_reg ^ occ_reg[0];

        req_pc_next    = req_pc_reg;
        rsp_valid_next = issue;
        rsp_pc_next    = req_pc_reg;
        occ_next       = occ_reg + {1'b0, push} - {1'b0, pop};
        head_next      = pop ? ~head_reg : head_reg;

        if (issue) begin
            req_pc_next = req_pc_reg + 32'd4;
        end

        // Redirect overrides everything: the current response is dropped
        // and the buffer is emptied (a pop this cycle is still delivered).
        if (redirect_valid) begin
            req_pc_next    = redirect_pc & PC_ALIGN;
            rsp_valid_next = 1'b0;
            occ_next       = 2'd0;
            head_next      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_pc_reg    <= RESET_PC & PC_ALIGN;
            rsp_valid_reg <= 1'b0;
            rsp_pc_reg    <= '0;
            occ_reg       <= 2'd0;
            head_reg      <= 1'b0;
        end else begin
            req_pc_reg    <= req_pc_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_pc_reg    <= rsp_pc_next;
            occ_reg       <= occ_next;
            head_reg      <= head_next;
        end
    end

    // Buffer entries: written at the tail when a response lands,
    // except in a redirect cycle where the returning word is stale.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_buf
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    buf_pc_reg[gi]   <= '0;
                    buf_inst_reg[gi] <= NOP;
                end else if (push && !redirect_valid && (tail == 1'(gi))) begin
                    buf_pc_reg[gi]   <= rsp_pc_reg;
                    buf_inst_reg[gi] <= imem_rdata;
                end
            end
        end
    endgenerate

    assign imem_addr = {2'b00, req_pc_reg[31:2]};
    assign out_valid = (occ_reg != 2'd0);
    assign out_pc    = buf_pc_reg[head_reg];
    assign out_inst  = buf_inst_reg[head_reg];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];

    // Expected delivery order and next PC to extend it with
    logic [31:0] exp_q [$];
    logic [31:0] gen_pc;

    logic        stall_prev;
    logic [31:0] held_pc;
    logic [31:0] held_inst;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
    );

    always #5 clk = ~clk;

    // Instruction memory: one-cycle read latency, aliased over 256 words
    always @(posedge clk) imem_rdata <= mem[imem_addr[7:0]];

    function automatic logic [31:0] mem_of(input logic [31:0] pc);
        logic [31:0] w;
        w = pc >> 2;
        return mem[w[7:0]];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    task automatic topup();
        while (exp_q.size() < 4) begin
            exp_q.push_back(gen_pc);
            gen_pc = gen_pc + 32'd4;
        end
    endtask

    // Drive one cycle of inputs (at posedge+1) and advance to the next posedge+1.
    task automatic cyc(input logic rdy, input logic redir, input logic [31:0] tgt);
        logic [31:0] keep;
        out_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        if (redir) begin
            // The head handshaken in this cycle still counts as delivered.
            if (out_valid && rdy && exp_q.size() > 0) begin
                keep = exp_q[0];
                exp_q.delete();
                exp_q.push_back(keep);
            end else begin
                exp_q.delete();
            end
            gen_pc = tgt & 32'hFFFF_FFFC;
        end
        topup();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        #1;
        exp_q.delete();
        gen_pc = 32'h0;
        topup();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_inst", out_inst, 32'h0000_0013);
        chk("rst_imem_addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: pops expected PCs on each handshake, checks stall stability
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", {31'b0, out_valid}, 32'd1);
                chk("stall_pc", out_pc, held_pc);
                chk("stall_inst", out_inst, held_inst);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output_pc", out_pc, 32'hDEAD_BEEF);
                end else begin
                    chk("out_pc", out_pc, exp_q[0]);
                    chk("out_inst", out_inst, mem_of(exp_q[0]));
                    $display("pop pc=%08h inst=%08h", out_pc, out_inst);
                    void'(exp_q.pop_front());
                end
            end
            stall_prev = out_valid && !out_ready && !redirect_valid;
            held_pc    = out_pc;
            held_inst  = out_inst;
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h100 + i;
        stall_prev = 1'b0;
        rst_n = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        @(posedge clk);
        #1;

        // 1. Reset latency and streaming
        do_reset();
        cyc(1, 0, 0);
        chk("t1_valid_cyc1", {31'b0, out_valid}, 32'd0);
        cyc(1, 0, 0);
        chk("t1_valid_cyc2", {31'b0, out_valid}, 32'd1);
        chk("t1_first_pc", out_pc, 32'h0);
        chk("t1_first_inst", out_inst, 32'h100);
        repeat (3) cyc(1, 0, 0);

        // 2. Stall
        do_reset();
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("t2_first_valid", {31'b0, out_valid}, 32'd1);
        repeat (5) cyc(0, 0, 0);
        chk("t2_hold_pc", out_pc, 32'h0);
        chk("t2_req_stop", imem_addr, 32'd2);
        repeat (6) cyc(1, 0, 0);

        // 3. Redirect with a full buffer
        repeat (4) cyc(0, 0, 0);
        cyc(0, 1, 32'h40);
        chk("t3_gap0", {31'b0, out_valid}, 32'd0);
        cyc(1, 0, 0);
        chk("t3_gap1", {31'b0, out_valid}, 32'd0);
        cyc(1, 0, 0);
        chk("t3_valid", {31'b0, out_valid}, 32'd1);
        chk("t3_pc", out_pc, 32'h40);
        repeat (3) cyc(1, 0, 0);

        // 4. Redirect coinciding with a pop
        chk("t4_pre_valid", {31'b0, out_valid}, 32'd1);
        cyc(1, 1, 32'h43);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk("t4_pc", out_pc, 32'h40);
        repeat (2) cyc(1, 0, 0);

        // 5. PC wrap
        cyc(1, 1, 32'hFFFF_FFFC);
        chk("t5_addr0", imem_addr, 32'h3FFF_FFFF);
        cyc(1, 0, 0);
        chk("t5_addr1", imem_addr, 32'h0);
        cyc(1, 0, 0);
        chk("t5_pc0", out_pc, 32'hFFFF_FFFC);
        cyc(1, 0, 0);
        chk("t5_pc1", out_pc, 32'h0);
        repeat (2) cyc(1, 0, 0);

        // 6. Random traffic
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 2999) == 0) begin
                do_reset();
            end else begin
                cyc(($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
                    $urandom());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
